// File: rtl/branch_form_decoder.sv
// Second-stage decoder for b / bc / bclr / bcctr. Emits branch-unit micro-ops and splits
// link-register updates into a trailing micro-op.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | ready to accept a new branch instruction
//  LINK  | micro-op 0 issued with LK=1; LR-write micro-op 1 still owed
module branch_form_decoder #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 6,
    parameter int funcUnitCodeSize        = 3,
    parameter int BranchUnitID            = 6,
    parameter int IFormBit                = 0,
    parameter int BFormBit                = 1,
    parameter int XLFormBit               = 11,
    parameter int invalidCountWidth       = 16,
    parameter int DecoderInstance         = 0
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [25:0]                        instFormat_i,
    input  logic [opcodeSize-1:0]              instructionOpcode_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    output logic                               busy_o,
    output logic                               enable_o,
    output logic [opcodeSize-1:0]              instructionOpcode_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [25:0]                        instructionBody_o,
    output logic                               readsCTR_o,
    output logic                               writesCTR_o,
    output logic                               readsLR_o,
    output logic                               writesLR_o,
    output logic [addressWidth-1:0]            linkAddress_o,
    output logic [invalidCountWidth-1:0]       invalidCount_o
);
    localparam int IW = instructionWidth;
    // PowerPC numbers instruction bits from the MSB, so bit k lives at index IW-1-k
    localparam int Bo2Idx = IW - 1 - 8;
    localparam int LkIdx  = IW - 1 - 31;
    localparam int XoHi   = IW - 1 - 21;
    localparam int XoLo   = IW - 1 - 30;

    localparam logic [opcodeSize-1:0]   OpBc     = opcodeSize'(16);
    localparam logic [opcodeSize-1:0]   OpB      = opcodeSize'(18);
    localparam logic [opcodeSize-1:0]   OpXl     = opcodeSize'(19);
    localparam logic [9:0]              XoBclr   = 10'd16;
    localparam logic [9:0]              XoBcctr  = 10'd528;
    localparam logic [addressWidth-1:0] Low32    = addressWidth'(64'hFFFF_FFFF);
    localparam logic [addressWidth-1:0] LinkStep = addressWidth'(4);

    typedef enum logic {IDLE, LINK} state_t;
    state_t state, state_next;

    logic       bo2, lk;
    logic [9:0] xo;
    logic       dec_valid, dec_rc, dec_wc, dec_rl;
    logic [addressWidth-1:0] link_sum, link_calc;

    logic                               enable_next;
    logic [opcodeSize-1:0]              opcode_next;
    logic [addressWidth-1:0]            address_next;
    logic [funcUnitCodeSize-1:0]        fu_next;
    logic [instructionCounterWidth-1:0] maj_next;
    logic [instMinIdWidth-1:0]          min_next;
    logic                               is64_next;
    logic [PidSize-1:0]                 pid_next;
    logic [TidSize-1:0]                 tid_next;
    logic [25:0]                        body_next;
    logic                               rc_next, wc_next, rl_next, wl_next;
    logic [addressWidth-1:0]            link_next;
    logic [invalidCountWidth-1:0]       count_next;

    logic unused_ok;
    assign unused_ok = (^instruction_i[IW-1:IW-6]) ^ (^instFormat_i) ^ (DecoderInstance != 0);

    assign busy_o = stall_i || (state == LINK);

    always_comb begin
        bo2       = instruction_i[Bo2Idx];
        lk        = instruction_i[LkIdx];
        xo        = instruction_i[XoHi:XoLo];
        dec_valid = 1'b0;
        dec_rc    = 1'b0;
        dec_wc    = 1'b0;
        dec_rl    = 1'b0;
        case (instructionOpcode_i)
            OpB: dec_valid = instFormat_i[IFormBit];
            OpBc: begin
                dec_valid = instFormat_i[BFormBit];
                dec_rc    = !bo2;
                dec_wc    = !bo2;
            end
            OpXl: begin
                if (instFormat_i[XLFormBit]) begin
                    if (xo == XoBclr) begin
                        dec_valid = 1'b1;
                        dec_rl    = 1'b1;
                        dec_rc    = !bo2;
                        dec_wc    = !bo2;
                    end else if (xo == XoBcctr && bo2) begin
                        dec_valid = 1'b1;
                        dec_rc    = 1'b1;
                    end
                end
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // 32-bit mode wraps the return address within the low word
    assign link_sum  = instructionAddress_i + LinkStep;
    assign link_calc = is64Bit_i ? link_sum : (link_sum & Low32);

    always_comb begin
        state_next   = state;
        enable_next  = enable_o;
        opcode_next  = instructionOpcode_o;
        address_next = instructionAddress_o;
        fu_next      = functionalUnitType_o;
        maj_next     = instMajId_o;
        min_next     = instMinId_o;
        is64_next    = is64Bit_o;
        pid_next     = instPid_o;
        tid_next     = instTid_o;
        body_next    = instructionBody_o;
        rc_next      = readsCTR_o;
        wc_next      = writesCTR_o;
        rl_next      = readsLR_o;
        wl_next      = writesLR_o;
        link_next    = linkAddress_o;
        count_next   = invalidCount_o;
        if (!stall_i) begin
            if (state == LINK) begin
                state_next  = IDLE;
                enable_next = 1'b1;
                min_next    = instMinIdWidth'(1);
                rc_next     = 1'b0;
                wc_next     = 1'b0;
                rl_next     = 1'b0;
                wl_next     = 1'b1;
            end else if (enable_i) begin
                if (dec_valid) begin
                    state_next   = lk ? LINK : IDLE;
                    enable_next  = 1'b1;
                    opcode_next  = instructionOpcode_i;
                    address_next = instructionAddress_i;
                    fu_next      = funcUnitCodeSize'(BranchUnitID);
                    maj_next     = instructionMajId_i;
                    min_next     = '0;
                    is64_next    = is64Bit_i;
                    pid_next     = instructionPid_i;
                    tid_next     = instructionTid_i;
                    body_next    = instruction_i[IW-7:IW-32];
                    rc_next      = dec_rc;
                    wc_next      = dec_wc;
                    rl_next      = dec_rl;
                    wl_next      = 1'b0;
                    link_next    = link_calc;
                end else begin
                    enable_next = 1'b0;
                    if (invalidCount_o != '1)
                        count_next = invalidCount_o + invalidCountWidth'(1);
                end
            end else begin
                enable_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            enable_o             <= 1'b0;
            instructionOpcode_o  <= '0;
            instructionAddress_o <= '0;
            functionalUnitType_o <= '0;
            instMajId_o          <= '0;
            instMinId_o          <= '0;
            is64Bit_o            <= 1'b0;
            instPid_o            <= '0;
            instTid_o            <= '0;
            instructionBody_o    <= '0;
            readsCTR_o           <= 1'b0;
            writesCTR_o          <= 1'b0;
            readsLR_o            <= 1'b0;
            writesLR_o           <= 1'b0;
            linkAddress_o        <= '0;
            invalidCount_o       <= '0;
        end else begin
            enable_o             <= enable_next;
            instructionOpcode_o  <= opcode_next;
            instructionAddress_o <= address_next;
            functionalUnitType_o <= fu_next;
            instMajId_o          <= maj_next;
            instMinId_o          <= min_next;
            is64Bit_o            <= is64_next;
            instPid_o            <= pid_next;
            instTid_o            <= tid_next;
            instructionBody_o    <= body_next;
            readsCTR_o           <= rc_next;
            writesCTR_o          <= wc_next;
            readsLR_o            <= rl_next;
            writesLR_o           <= wl_next;
            linkAddress_o        <= link_next;
            invalidCount_o       <= count_next;
        end
    end

endmodule

// File: tb/tb_branch_form_decoder.sv
// Bench for branch_form_decoder: directed scenarios plus randomized instructions checked
// against a transaction-level reference model.
module tb_branch_form_decoder;
    localparam int CW = 8;
    localparam logic [CW-1:0] CntMax = '1;

    logic clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    logic        reset_i, enable_i, stall_i, is64Bit_i;
    logic [25:0] instFormat_i;
    logic [5:0]  instructionOpcode_i;
    logic [31:0] instruction_i;
    logic [63:0] instructionAddress_i, instructionMajId_i;
    logic [19:0] instructionPid_i;
    logic [15:0] instructionTid_i;

    logic          busy_o, enable_o, is64Bit_o;
    logic [5:0]    instructionOpcode_o;
    logic [63:0]   instructionAddress_o, instMajId_o, linkAddress_o;
    logic [2:0]    functionalUnitType_o;
    logic [6:0]    instMinId_o;
    logic [19:0]   instPid_o;
    logic [15:0]   instTid_o;
    logic [25:0]   instructionBody_o;
    logic          readsCTR_o, writesCTR_o, readsLR_o, writesLR_o;
    logic [CW-1:0] invalidCount_o;

    branch_form_decoder #(.invalidCountWidth(CW)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .stall_i(stall_i),
        .instFormat_i(instFormat_i), .instructionOpcode_i(instructionOpcode_i),
        .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
        .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
        .instructionTid_i(instructionTid_i), .instructionMajId_i(instructionMajId_i),
        .busy_o(busy_o), .enable_o(enable_o), .instructionOpcode_o(instructionOpcode_o),
        .instructionAddress_o(instructionAddress_o), .functionalUnitType_o(functionalUnitType_o),
        .instMajId_o(instMajId_o), .instMinId_o(instMinId_o), .is64Bit_o(is64Bit_o),
        .instPid_o(instPid_o), .instTid_o(instTid_o), .instructionBody_o(instructionBody_o),
        .readsCTR_o(readsCTR_o), .writesCTR_o(writesCTR_o), .readsLR_o(readsLR_o),
        .writesLR_o(writesLR_o), .linkAddress_o(linkAddress_o), .invalidCount_o(invalidCount_o)
    );

    typedef struct {
        logic en; logic [5:0] opc; logic [63:0] addr; logic [2:0] fu; logic [63:0] maj;
        logic [6:0] mn; logic is64; logic [19:0] pid; logic [15:0] tid; logic [25:0] body;
        logic rc; logic wc; logic rl; logic wl; logic [63:0] link; logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp;
    int tests = 0;
    int fails = 0;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".enable"}, enable_o, exp.en);
        chk({tag, ".opcode"}, instructionOpcode_o, exp.opc);
        chk({tag, ".address"}, instructionAddress_o, exp.addr);
        chk({tag, ".fu"}, functionalUnitType_o, exp.fu);
        chk({tag, ".majId"}, instMajId_o, exp.maj);
        chk({tag, ".minId"}, instMinId_o, exp.mn);
        chk({tag, ".is64"}, is64Bit_o, exp.is64);
        chk({tag, ".pid"}, instPid_o, exp.pid);
        chk({tag, ".tid"}, instTid_o, exp.tid);
        chk({tag, ".body"}, instructionBody_o, exp.body);
        chk({tag, ".readsCTR"}, readsCTR_o, exp.rc);
        chk({tag, ".writesCTR"}, writesCTR_o, exp.wc);
        chk({tag, ".readsLR"}, readsLR_o, exp.rl);
        chk({tag, ".writesLR"}, writesLR_o, exp.wl);
        chk({tag, ".link"}, linkAddress_o, exp.link);
        chk({tag, ".invalidCount"}, invalidCount_o, exp.cnt);
    endtask

    // PowerPC bit k counts from the MSB of the 32-bit word
    function automatic logic pbit(input logic [31:0] w, input int k);
        return w[31-k];
    endfunction

    function automatic logic [31:0] put(input logic [31:0] w, input int lo, input int hi, input int val);
        int v;
        v = val;
        for (int k = hi; k >= lo; k--) begin
            w[31-k] = v[0];
            v = v >> 1;
        end
        return w;
    endfunction

    task automatic ref_decode(input logic [5:0] opc, input logic [25:0] fmt, input logic [31:0] w,
                              output logic ok, output logic rc, output logic wc, output logic rl);
        int xo;
        logic bo2;
        bo2 = pbit(w, 8);
        xo = 0;
        for (int k = 21; k <= 30; k++) xo = xo * 2 + int'(pbit(w, k));
        ok = 0; rc = 0; wc = 0; rl = 0;
        if (opc == 18 && fmt[0]) ok = 1;
        else if (opc == 16 && fmt[1]) begin ok = 1; rc = !bo2; wc = !bo2; end
        else if (opc == 19 && fmt[11] && xo == 16) begin ok = 1; rl = 1; rc = !bo2; wc = !bo2; end
        else if (opc == 19 && fmt[11] && xo == 528 && bo2) begin ok = 1; rc = 1; end
    endtask

    task automatic load(input int opc, input int fbit, input int bo, input int lk, input int xo);
        logic [31:0] w;
        w = $urandom;
        w = put(w, 6, 10, bo);
        w = put(w, 21, 30, xo);
        w = put(w, 31, 31, lk);
        instruction_i        = w;
        instructionOpcode_i  = 6'(opc);
        instFormat_i         = '0;
        instFormat_i[fbit]   = 1'b1;
        instructionAddress_i = {$urandom, $urandom};
        instructionMajId_i   = {$urandom, $urandom};
        instructionPid_i     = 20'($urandom);
        instructionTid_i     = 16'($urandom);
        is64Bit_i            = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input int stall_cycles, input string tag);
        logic ok, rc, wc, rl, lk;
        logic [63:0] a;
        ref_decode(instructionOpcode_i, instFormat_i, instruction_i, ok, rc, wc, rl);
        lk = pbit(instruction_i, 31);
        a = instructionAddress_i + 64'd4;
        if (!is64Bit_i) a = a % 64'h1_0000_0000;
        stall_i = 0;
        enable_i = 1;
        step();
        if (ok) begin
            exp.en = 1; exp.opc = instructionOpcode_i; exp.addr = instructionAddress_i;
            exp.fu = 3'd6; exp.maj = instructionMajId_i; exp.mn = 0; exp.is64 = is64Bit_i;
            exp.pid = instructionPid_i; exp.tid = instructionTid_i;
            exp.body = 26'(instruction_i % 32'h0400_0000);
            exp.rc = rc; exp.wc = wc; exp.rl = rl; exp.wl = 0; exp.link = a;
        end else begin
            exp.en = 0;
            if (exp.cnt != CntMax) exp.cnt = CW'(exp.cnt + 1);
        end
        check_outputs(tag);
        chk({tag, ".busy"}, busy_o, ok && lk);
        if (ok && lk) begin
            // a different instruction is offered while busy; it must be ignored
            load($urandom_range(0, 63), $urandom_range(0, 25), $urandom_range(0, 31),
                 $urandom_range(0, 1), $urandom_range(0, 1023));
            enable_i = 1;
            for (int i = 0; i < stall_cycles; i++) begin
                stall_i = 1;
                step();
                check_outputs({tag, ".hold"});
                chk({tag, ".hold.busy"}, busy_o, 1'b1);
            end
            stall_i = 0;
            step();
            exp.en = 1; exp.mn = 1; exp.rc = 0; exp.wc = 0; exp.rl = 0; exp.wl = 1;
            check_outputs({tag, ".lr"});
            chk({tag, ".lr.busy"}, busy_o, 1'b0);
        end
        enable_i = 0;
    endtask

    task automatic idle_cycle(input string tag);
        stall_i  = 1'($urandom_range(0, 1));
        enable_i = stall_i ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        if (!stall_i) exp.en = 0;
        check_outputs(tag);
        chk({tag, ".busy"}, busy_o, stall_i);
        stall_i  = 0;
        enable_i = 0;
    endtask

    initial begin
        int kind, fb, opc, xo;
        exp = '{default: 0};
        reset_i = 1; enable_i = 0; stall_i = 0;
        load(0, 0, 0, 0, 0);
        step();
        step();
        check_outputs("reset");
        chk("reset.busy", busy_o, 1'b0);
        reset_i = 0;

        load(16, 1, 5'b00100, 0, 0);
        instructionAddress_i = 64'h1000;
        instructionMajId_i = 64'd5;
        issue(0, "bc");
        chk("bc.link_abs", linkAddress_o, 64'h1004);
        chk("bc.readsCTR_abs", readsCTR_o, 1'b0);

        load(19, 11, 0, 1, 16);
        issue(0, "bclr");

        load(18, 0, 0, 1, 0);
        instructionAddress_i = 64'hFFFF_FFFF_FFFF_FFFC;
        is64Bit_i = 1;
        issue(0, "b_wrap64");
        chk("b_wrap64.link_abs", linkAddress_o, 64'h0);
        load(18, 0, 0, 1, 0);
        instructionAddress_i = 64'h0000_0000_FFFF_FFFC;
        is64Bit_i = 0;
        issue(0, "b_wrap32");
        chk("b_wrap32.link_abs", linkAddress_o, 64'h0);

        load(19, 11, 0, 0, 528);
        issue(0, "bcctr_bo2");
        load(19, 11, $urandom_range(0, 31), 0, 100);
        issue(0, "xl_badxo");
        load(16, 0, 5'b00100, 0, 0);
        issue(0, "bc_iform");
        chk("invalid3.count_abs", invalidCount_o, 3);

        load(16, 1, 5'b00100, 1, 0);
        issue(3, "stall");

        load(16, 1, 0, 1, 0);
        enable_i = 1;
        step();
        chk("rst_link.busy_before", busy_o, 1'b1);
        enable_i = 0;
        reset_i = 1;
        stall_i = 1;
        step();
        exp = '{default: 0};
        check_outputs("rst_link");
        reset_i = 0;
        stall_i = 0;
        #1;
        chk("rst_link.busy", busy_o, 1'b0);
        step();
        check_outputs("rst_link.drop");

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 5);
            fb   = (kind == 0) ? 0 : (kind == 1) ? 1 : 11;
            if ($urandom_range(0, 5) == 0) fb = $urandom_range(0, 25);
            opc  = (kind == 0) ? 18 : (kind == 1) ? 16 : (kind == 5) ? $urandom_range(0, 63) : 19;
            xo   = (kind == 2) ? 16 : (kind == 3) ? 528 : $urandom_range(0, 1023);
            load(opc, fb, $urandom_range(0, 31), $urandom_range(0, 1), xo);
            issue($urandom_range(0, 2), "rand");
            if ($urandom_range(0, 3) == 0) idle_cycle("idle");
        end

        for (int n = 0; n < 300; n++) begin
            load(0, $urandom_range(0, 25), 0, 0, 0);
            issue(0, "sat");
        end
        chk("sat.count_abs", invalidCount_o, CntMax);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
